// File: rtl/wb_arb_pkg.sv
// Shared types and sizing helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  // Width of an index into n controllers; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Watchdog counter width: wide enough for the limit, clamped to 8..16 bits.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/wishbone_arbiter_if.sv
// Bus bundle for the arbiter: NUM_CTRL controller-side channels plus one device port.
// slave = the arbiter's view; master = the controllers and the device around it.
interface wishbone_arbiter_if #(
  parameter int NUM_CTRL  = 4,
  parameter int DAT_WIDTH = 8
);

  logic [NUM_CTRL-1:0]           c_cyc_i;
  logic [NUM_CTRL-1:0]           c_stb_i;
  logic [NUM_CTRL-1:0]           c_we_i;
  logic [NUM_CTRL*DAT_WIDTH-1:0] c_dat_i;
  logic [NUM_CTRL-1:0]           c_ack_o;
  logic [NUM_CTRL-1:0]           c_err_o;
  logic [NUM_CTRL-1:0]           c_rty_o;
  logic [NUM_CTRL-1:0]           c_stall_o;

  logic                 d_cyc_o;
  logic                 d_stb_o;
  logic                 d_we_o;
  logic [DAT_WIDTH-1:0] d_dat_o;
  logic                 d_ack_i;
  logic                 d_err_i;
  logic                 d_rty_i;
  logic                 d_stall_i;

  modport slave (
    input  c_cyc_i, c_stb_i, c_we_i, c_dat_i,
    output c_ack_o, c_err_o, c_rty_o, c_stall_o,
    output d_cyc_o, d_stb_o, d_we_o, d_dat_o,
    input  d_ack_i, d_err_i, d_rty_i, d_stall_i
  );

  modport master (
    output c_cyc_i, c_stb_i, c_we_i, c_dat_i,
    input  c_ack_o, c_err_o, c_rty_o, c_stall_o,
    input  d_cyc_o, d_stb_o, d_we_o, d_dat_o,
    output d_ack_i, d_err_i, d_rty_i, d_stall_i
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request searching upward from last_idx+1.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] sel,
  output logic             valid
);

  int cand;

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves a value held and no latch is inferred.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(last_idx) + i;
      if (cand >= N) cand = cand - N;
      if (!valid && req[cand[IDX_W-1:0]]) begin
        valid = 1'b1;
        sel   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone device among NUM_CTRL controllers.
// Optional watchdog enabled by defining WB_ARBITER_TIMEOUT_EN (adds timeout_o).
module wishbone_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_CTRL       = 4,
  parameter int DAT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  wishbone_arbiter_if.slave   bus,
  output logic [NUM_CTRL-1:0] grant_o,
  output logic                busy_o
`ifdef WB_ARBITER_TIMEOUT_EN
  ,
  output logic                timeout_o
`endif
);

  localparam int IDX_W = idx_width(NUM_CTRL);

  if (NUM_CTRL < 2 || NUM_CTRL > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("wishbone_arbiter: NUM_CTRL must be 2..8 and TIMEOUT_CYCLES positive");
  end

  arb_state_t           state;
  logic [IDX_W-1:0]     last_idx;
  logic [NUM_CTRL-1:0]  pick_req;
  logic [IDX_W-1:0]     pick_sel;
  logic                 pick_valid;
  logic                 timeout;

  rr_picker #(
    .N     (NUM_CTRL),
    .IDX_W (IDX_W)
  ) u_picker (
    .req      (pick_req),
    .last_idx (last_idx),
    .sel      (pick_sel),
    .valid    (pick_valid)
  );

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0]    wd_cnt;
  logic [NUM_CTRL-1:0] mask;

  assign timeout   = busy_o && (wd_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign timeout_o = timeout;
  assign pick_req  = bus.c_cyc_i & ~mask;

  // A timed-out controller stays masked until it has been seen with CYC low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt <= '0;
      mask   <= '0;
    end else begin
      if (!busy_o || bus.d_ack_i || bus.d_err_i || bus.d_rty_i) begin
        wd_cnt <= '0;
      end else if (!timeout) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      mask <= (mask & bus.c_cyc_i) | (timeout ? grant_o : '0);
    end
  end
`else
  assign timeout  = 1'b0;
  assign pick_req = bus.c_cyc_i;
`endif

  // NOTE: reset is synchronous and active-high, so it lives inside the clocked
  // branch rather than in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      grant_o  <= '0;
      busy_o   <= 1'b0;
      last_idx <= IDX_W'(NUM_CTRL - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= GRANT;
            grant_o  <= NUM_CTRL'(1) << pick_sel;
            busy_o   <= 1'b1;
            last_idx <= pick_sel;
          end
        end
        GRANT: begin
          if (!bus.c_cyc_i[last_idx] || timeout) begin
            state   <= IDLE;
            grant_o <= '0;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  // While granted, last_idx is the granted controller's index.
  assign bus.d_cyc_o = busy_o & bus.c_cyc_i[last_idx] & ~timeout;
  assign bus.d_stb_o = busy_o & bus.c_stb_i[last_idx];
  assign bus.d_we_o  = busy_o & bus.c_we_i[last_idx];
  assign bus.d_dat_o = busy_o ? bus.c_dat_i[last_idx*DAT_WIDTH +: DAT_WIDTH] : '0;

  assign bus.c_ack_o   = grant_o & {NUM_CTRL{bus.d_ack_i}};
  assign bus.c_err_o   = grant_o & {NUM_CTRL{bus.d_err_i | timeout}};
  assign bus.c_rty_o   = grant_o & {NUM_CTRL{bus.d_rty_i}};
  assign bus.c_stall_o = ~grant_o | {NUM_CTRL{bus.d_stall_i}};

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Scoreboard bench for wishbone_arbiter (NUM_CTRL=4, DAT_WIDTH=8): directed stimulus
// pushes per-cycle expectations and expected grant order; monitors compare on negedge.
module tb_wishbone_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] grant;
  logic       busy;
`ifdef WB_ARBITER_TIMEOUT_EN
  logic       timeout;
`endif

  always #5 clk = ~clk;

  wishbone_arbiter_if #(.NUM_CTRL(4), .DAT_WIDTH(8)) bus ();

  wishbone_arbiter #(
    .NUM_CTRL  (4),
    .DAT_WIDTH (8)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .grant_o (grant),
`ifdef WB_ARBITER_TIMEOUT_EN
    .timeout_o (timeout),
`endif
    .busy_o  (busy)
  );

  typedef struct {
    string      name;
    int         stamp;
    logic [3:0] grant;
    logic       busy;
    logic       d_cyc;
    logic       d_stb;
    logic       d_we;
    logic [7:0] d_dat;
    logic [3:0] ack;
    logic [3:0] err;
    logic [3:0] rty;
    logic [3:0] stall;
  } snap_t;

  snap_t      exp_q[$];
  logic [3:0] grant_q[$];
  snap_t      mon_e;
  logic [3:0] exp_g;
  logic [3:0] prev_grant = 4'b0;
  int         cyc_n = 0;
  int         total = 0;
  int         bad   = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Per-cycle output scoreboard.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].stamp == cyc_n) begin
      mon_e = exp_q.pop_front();
      total++;
      if ({grant, busy, bus.d_cyc_o, bus.d_stb_o, bus.d_we_o, bus.d_dat_o,
           bus.c_ack_o, bus.c_err_o, bus.c_rty_o, bus.c_stall_o} !==
          {mon_e.grant, mon_e.busy, mon_e.d_cyc, mon_e.d_stb, mon_e.d_we, mon_e.d_dat,
           mon_e.ack, mon_e.err, mon_e.rty, mon_e.stall}) begin
        bad++;
        $display("FAIL %s: got grant=%b busy=%b cyc=%b stb=%b we=%b dat=%h ack=%b err=%b rty=%b stall=%b; want grant=%b busy=%b cyc=%b stb=%b we=%b dat=%h ack=%b err=%b rty=%b stall=%b",
                 mon_e.name, grant, busy, bus.d_cyc_o, bus.d_stb_o, bus.d_we_o, bus.d_dat_o,
                 bus.c_ack_o, bus.c_err_o, bus.c_rty_o, bus.c_stall_o,
                 mon_e.grant, mon_e.busy, mon_e.d_cyc, mon_e.d_stb, mon_e.d_we, mon_e.d_dat,
                 mon_e.ack, mon_e.err, mon_e.rty, mon_e.stall);
      end
    end
  end

  // Grant-order scoreboard: checked whenever a new grant appears.
  always @(negedge clk) begin
    if (grant !== 4'b0 && prev_grant === 4'b0) begin
      total++;
      if (grant_q.size() == 0) begin
        bad++;
        $display("FAIL grant_order: got grant=%b, want no further grant", grant);
      end else begin
        exp_g = grant_q.pop_front();
        if (grant !== exp_g) begin
          bad++;
          $display("FAIL grant_order: got grant=%b, want %b", grant, exp_g);
        end
      end
    end
    prev_grant <= grant;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] g, input logic b,
                            input logic cy, input logic sb, input logic w,
                            input logic [7:0] dt, input logic [3:0] ak,
                            input logic [3:0] er, input logic [3:0] ry,
                            input logic [3:0] st);
    snap_t e;
    e.name  = name;
    e.stamp = cyc_n;
    e.grant = g;
    e.busy  = b;
    e.d_cyc = cy;
    e.d_stb = sb;
    e.d_we  = w;
    e.d_dat = dt;
    e.ack   = ak;
    e.err   = er;
    e.rty   = ry;
    e.stall = st;
    exp_q.push_back(e);
  endtask

  task automatic expect_idle(input string name);
    expect_out(name, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
               4'b0000, 4'b0000, 4'b0000, 4'b1111);
  endtask

  // Round-robin table: granted index, one-hot, its WE, its data, expected stall.
  int         rr_idx[5]   = '{0, 1, 2, 3, 0};
  logic [3:0] rr_g[5]     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic       rr_we[5]    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] rr_dat[5]   = '{8'h11, 8'h22, 8'hA5, 8'h33, 8'h11};
  logic [3:0] rr_st[5]    = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    rst           = 1'b1;
    bus.c_cyc_i   = 4'b0000;
    bus.c_stb_i   = 4'b0000;
    bus.c_we_i    = 4'b0101;
    bus.c_dat_i   = {8'h33, 8'hA5, 8'h22, 8'h11};
    bus.d_ack_i   = 1'b0;
    bus.d_err_i   = 1'b0;
    bus.d_rty_i   = 1'b0;
    bus.d_stall_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    expect_idle("reset_state");
    tick();

    bus.d_ack_i = 1'b1;
    bus.d_err_i = 1'b1;
    bus.d_rty_i = 1'b1;
    expect_idle("idle_resp_dropped");
    tick();
    bus.d_ack_i = 1'b0;
    bus.d_err_i = 1'b0;
    bus.d_rty_i = 1'b0;

    // Round robin: everyone requests, each holds CYC for 3 granted cycles.
    bus.c_cyc_i = 4'b1111;
    bus.c_stb_i = 4'b1111;
    expect_idle("rr_req");
    for (int i = 0; i < 5; i++) grant_q.push_back(rr_g[i]);
    tick();
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 3; j++) begin
        expect_out($sformatf("rr%0d_hold%0d", i, j), rr_g[i], 1'b1, 1'b1, 1'b1,
                   rr_we[i], rr_dat[i], 4'b0, 4'b0, 4'b0, rr_st[i]);
        tick();
      end
      bus.c_cyc_i[rr_idx[i]] = 1'b0;
      bus.c_stb_i[rr_idx[i]] = 1'b0;
      expect_out($sformatf("rr%0d_drop", i), rr_g[i], 1'b1, 1'b0, 1'b0,
                 rr_we[i], rr_dat[i], 4'b0, 4'b0, 4'b0, rr_st[i]);
      tick();
      if (i < 4) begin
        bus.c_cyc_i[rr_idx[i]] = 1'b1;
        bus.c_stb_i[rr_idx[i]] = 1'b1;
      end else begin
        bus.c_cyc_i = 4'b0000;
        bus.c_stb_i = 4'b0000;
      end
      expect_idle($sformatf("rr%0d_dead", i));
      tick();
    end

    // Single requester with each response type routed to it alone.
    bus.c_cyc_i = 4'b0100;
    bus.c_stb_i = 4'b0100;
    expect_idle("single_req");
    grant_q.push_back(4'b0100);
    tick();
    expect_out("single_grant", 4'b0100, 1, 1, 1, 1, 8'hA5, 4'b0000, 4'b0000, 4'b0000, 4'b1011);
    tick();
    bus.d_ack_i = 1'b1;
    expect_out("single_ack", 4'b0100, 1, 1, 1, 1, 8'hA5, 4'b0100, 4'b0000, 4'b0000, 4'b1011);
    tick();
    bus.d_ack_i = 1'b0;
    bus.d_err_i = 1'b1;
    expect_out("single_err", 4'b0100, 1, 1, 1, 1, 8'hA5, 4'b0000, 4'b0100, 4'b0000, 4'b1011);
    tick();
    bus.d_err_i = 1'b0;
    bus.d_rty_i = 1'b1;
    expect_out("single_rty", 4'b0100, 1, 1, 1, 1, 8'hA5, 4'b0000, 4'b0000, 4'b0100, 4'b1011);
    tick();
    bus.d_rty_i = 1'b0;
    bus.c_cyc_i = 4'b0000;
    bus.c_stb_i = 4'b0000;
    expect_out("single_drop", 4'b0100, 1, 0, 0, 1, 8'hA5, 4'b0000, 4'b0000, 4'b0000, 4'b1011);
    tick();

    // Isolation: controller 3 requests during controller 1's grant.
    bus.c_cyc_i = 4'b0010;
    bus.c_stb_i = 4'b0010;
    expect_idle("iso_req");
    grant_q.push_back(4'b0010);
    grant_q.push_back(4'b1000);
    tick();
    bus.c_cyc_i = 4'b1010;
    bus.c_stb_i = 4'b1010;
    bus.d_ack_i = 1'b1;
    expect_out("iso_ack", 4'b0010, 1, 1, 1, 0, 8'h22, 4'b0010, 4'b0000, 4'b0000, 4'b1101);
    tick();
    bus.d_ack_i = 1'b0;
    expect_out("iso_hold", 4'b0010, 1, 1, 1, 0, 8'h22, 4'b0000, 4'b0000, 4'b0000, 4'b1101);
    tick();
    bus.c_cyc_i = 4'b1000;
    bus.c_stb_i = 4'b1000;
    expect_out("iso_drop", 4'b0010, 1, 0, 0, 0, 8'h22, 4'b0000, 4'b0000, 4'b0000, 4'b1101);
    tick();
    expect_idle("iso_dead");
    tick();
    expect_out("iso_next", 4'b1000, 1, 1, 1, 0, 8'h33, 4'b0000, 4'b0000, 4'b0000, 4'b0111);
    tick();
    bus.c_cyc_i = 4'b0000;
    bus.c_stb_i = 4'b0000;
    expect_out("iso_next_drop", 4'b1000, 1, 0, 0, 0, 8'h33, 4'b0000, 4'b0000, 4'b0000, 4'b0111);
    tick();

    // Stall pass-through for controller 0, STB toggling underneath.
    bus.c_cyc_i = 4'b0001;
    bus.c_stb_i = 4'b0001;
    expect_idle("stall_req");
    grant_q.push_back(4'b0001);
    tick();
    bus.d_stall_i = 1'b1;
    expect_out("stall_hi1", 4'b0001, 1, 1, 1, 1, 8'h11, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    tick();
    bus.c_stb_i = 4'b0000;
    expect_out("stall_hi2", 4'b0001, 1, 1, 0, 1, 8'h11, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    tick();
    bus.d_stall_i = 1'b0;
    bus.c_stb_i   = 4'b0001;
    expect_out("stall_lo", 4'b0001, 1, 1, 1, 1, 8'h11, 4'b0000, 4'b0000, 4'b0000, 4'b1110);
    tick();
    bus.c_cyc_i = 4'b0000;
    bus.c_stb_i = 4'b0000;
    expect_out("stall_drop", 4'b0001, 1, 0, 0, 1, 8'h11, 4'b0000, 4'b0000, 4'b0000, 4'b1110);
    tick();

    // Reset during controller 2's grant; afterwards 0 must win over 3.
    bus.c_cyc_i = 4'b0100;
    bus.c_stb_i = 4'b0100;
    expect_idle("rstm_req");
    grant_q.push_back(4'b0100);
    grant_q.push_back(4'b0001);
    grant_q.push_back(4'b1000);
    tick();
    bus.d_ack_i = 1'b1;
    expect_out("rstm_grant", 4'b0100, 1, 1, 1, 1, 8'hA5, 4'b0100, 4'b0000, 4'b0000, 4'b1011);
    tick();
    rst         = 1'b1;
    bus.c_cyc_i = 4'b1101;
    bus.c_stb_i = 4'b1101;
    expect_out("rstm_assert", 4'b0100, 1, 1, 1, 1, 8'hA5, 4'b0100, 4'b0000, 4'b0000, 4'b1011);
    tick();
    rst         = 1'b0;
    bus.c_cyc_i = 4'b1001;
    bus.c_stb_i = 4'b1001;
    expect_idle("rstm_cleared");
    tick();
    bus.d_ack_i = 1'b0;
    expect_out("rstm_first", 4'b0001, 1, 1, 1, 1, 8'h11, 4'b0000, 4'b0000, 4'b0000, 4'b1110);
    tick();
    bus.c_cyc_i = 4'b1000;
    bus.c_stb_i = 4'b1000;
    expect_out("rstm_drop", 4'b0001, 1, 0, 0, 1, 8'h11, 4'b0000, 4'b0000, 4'b0000, 4'b1110);
    tick();
    expect_idle("rstm_dead");
    tick();
    expect_out("rstm_next", 4'b1000, 1, 1, 1, 0, 8'h33, 4'b0000, 4'b0000, 4'b0000, 4'b0111);
    tick();
    bus.c_cyc_i = 4'b0000;
    bus.c_stb_i = 4'b0000;
    expect_out("rstm_next_drop", 4'b1000, 1, 0, 0, 0, 8'h33, 4'b0000, 4'b0000, 4'b0000, 4'b0111);
    tick();
    expect_idle("final_idle");
    tick();
    tick();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    total++;
    if (grant_q.size() != 0) begin
      bad++;
      $display("FAIL grant_drain: got %0d expected grants never seen, want 0", grant_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter.md
Name: wishbone_arbiter

Overview:
- Shares one Wishbone device port among NUM_CTRL Wishbone controllers (debug-button sequencers, UART bridge, etc.).
- Round-robin grant per bus cycle; the grant is held for the whole CYC assertion.
- The granted controller's request signals are muxed to the device; the device's response signals are routed back to that controller only.
- Sits between controller-side and device-side endpoints of the project's wishbone interface (cyc/stb/we/dat, ack/err/rty/stall).

Parameters:
- NUM_CTRL, 4, number of controllers; 2..8.
- DAT_WIDTH, 8, data width, matching the interface's DAT_WIDTH.
- TIMEOUT_CYCLES, 255, watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- c_cyc_i  in  NUM_CTRL  per-controller CYC.
- c_stb_i  in  NUM_CTRL  per-controller STB.
- c_we_i  in  NUM_CTRL  per-controller WE.
- c_dat_i  in  NUM_CTRL*DAT_WIDTH  per-controller write data; controller k occupies bits [k*DAT_WIDTH +: DAT_WIDTH].
- c_ack_o  out  NUM_CTRL  per-controller ACK.
- c_err_o  out  NUM_CTRL  per-controller ERR.
- c_rty_o  out  NUM_CTRL  per-controller RTY.
- c_stall_o  out  NUM_CTRL  per-controller STALL.
- d_cyc_o  out  1  CYC to device.
- d_stb_o  out  1  STB to device.
- d_we_o  out  1  WE to device.
- d_dat_o  out  DAT_WIDTH  write data to device.
- d_ack_i  in  1  ACK from device.
- d_err_i  in  1  ERR from device.
- d_rty_i  in  1  RTY from device.
- d_stall_i  in  1  STALL from device.
- grant_o  out  NUM_CTRL  one-hot registered grant; all zero when idle.
- busy_o  out  1  high in GRANT state.

Behaviour:
- Clock and reset:
  - One clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values:
  - state=IDLE, grant_o=0, busy_o=0, last_idx=NUM_CTRL-1, so controller 0 has first priority.
  - All d_* outputs 0.
  - c_stall_o all 1; c_ack_o, c_err_o, c_rty_o all 0.
- FSM with two states:
  - IDLE: if any c_cyc_i is high, the picker selects the first set bit searching upward from last_idx+1 (modulo NUM_CTRL). Next cycle: state=GRANT, grant_o=onehot(sel), last_idx=sel.
  - GRANT: when c_cyc_i[g]=0 for the granted controller g, next cycle state=IDLE and grant_o=0.
- Latency:
  - Request seen at edge t gives grant_o at t+1; d_cyc_o follows in the same cycle.
  - There is one mandatory dead cycle between grants.
  - Earliest re-grant is 2 cycles after the granted controller drops CYC.
- Forward path (combinational on registered grant):
  - d_cyc_o = busy & c_cyc_i[g]. d_stb_o, d_we_o and d_dat_o come from controller g.
  - When idle, all d_* outputs are 0.
- Return path:
  - c_ack_o[g]=d_ack_i, c_err_o[g]=d_err_i, c_rty_o[g]=d_rty_i, c_stall_o[g]=d_stall_i.
  - Non-granted controllers: ack/err/rty=0, stall=1.
  - The arbiter neither counts nor buffers outstanding pipelined requests. The controller must keep CYC high until its responses complete.
- Simultaneous events:
  - Requests arriving during GRANT are ignored until IDLE.
  - If the granted controller drops CYC while others are requesting, the next grant goes to the nearest requester above g.
  - A single requester may be re-granted back-to-back, with the dead cycle between grants.
- Reset mid-transaction: grant is cleared at the reset edge, so d_cyc_o is 0 the following cycle. No response is forwarded after reset.
- Device responses arriving while idle are dropped.

Optional Feature:
- Macro: WB_ARBITER_TIMEOUT_EN.
- When defined:
  - An 8..16-bit watchdog counter clears on grant and on any d_ack_i, d_err_i or d_rty_i. It increments each GRANT cycle otherwise.
  - When the counter reaches TIMEOUT_CYCLES, c_err_o[g] pulses for 1 cycle, d_cyc_o is forced to 0 from that cycle, and state goes to IDLE.
  - Controller g is then masked from arbitration until it deasserts c_cyc_i[g] for at least one cycle.
  - An additional output timeout_o pulses for 1 cycle on expiry.
- When not defined: no counter, no timeout_o port; GRANT is held indefinitely while CYC is high.

Decomposition:
- Package wb_arb_pkg holds:
  - arb_state_t enum {IDLE, GRANT};
  - the function clog2-based idx width;
  - the localparam default TIMEOUT_CYCLES.
- Sub-module rr_picker is combinational. Inputs: req vector and last_idx. Outputs: sel index and valid. It is reusable by future arbiters.

Test Plan:
- Single request: NUM_CTRL=4, reset then c_cyc_i=4'b0100 at cycle 2 → grant_o=4'b0100 and d_cyc_o=1 at cycle 3. A device ack appears on c_ack_o[2] only.
- Round-robin fairness: all four hold CYC for 3 cycles each, then drop and re-request → grant order 0,1,2,3,0, with one idle cycle between grants.
- Isolation: controller 1 granted, d_ack_i=1 → c_ack_o=4'b0010, c_stall_o=4'b1101. Controller 3's stb/dat do not appear on d_*.
- Stall pass-through: granted controller 0 with d_stall_i=1 for 2 cycles → c_stall_o[0]=1 for those cycles; d_stb_o mirrors c_stb_i[0].
- Reset mid-cycle: rst_i=1 for 1 cycle during GRANT → next cycle grant_o=0, d_cyc_o=0, last_idx=3; the next request from 0 is granted first.
- Timeout (WB_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=10): grant controller 2, device silent → at cycle 10 c_err_o[2]=1 and timeout_o=1. Controller 2 is not re-granted until it drops CYC; controller 3 is granted meanwhile.
